// File: rtl/irq_vector_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_vector_responder_pkg                                    |
// | Purpose: Shared constants and types for the IM2 interrupt responder: |
// |          control port low byte, register indices and ack FSM states. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package irq_vector_responder_pkg;

  localparam logic [7:0] INTCTL_PORT_LO = 8'h3B;

  // Register selector carried on the high address byte.
  localparam logic [7:0] INTCTL_MASK  = 8'h00;
  localparam logic [7:0] INTCTL_VBASE = 8'h01;
  localparam logic [7:0] INTCTL_EOI   = 8'h02;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRIVE = 2'd2
  } irq_ack_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_bus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cpu_bus                                                     |
// | Purpose: Decoded Z80 CPU bus. Strobes are active-high.               |
// |   a[15:0] address, d[7:0] CPU write data, iorq/rd/wr/m1 strobes.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface cpu_bus;
  logic [15:0] a;
  logic [7:0]  d;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        m1;

  modport slave (input a, d, iorq, rd, wr, m1);
endinterface
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_prio_enc                                                |
// | Purpose: Lowest-index-wins priority encoder.                         |
// |   req_vec [NSRC] : request bits, index 0 highest priority            |
// |   idx     [IW]   : index of winning request                          |
// |   valid          : at least one request present                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int IW   = 2
) (
  input  logic [NSRC-1:0] req_vec,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_vector_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_vector_responder                                        |
// | Purpose: Multi-source Z80 IM2 interrupt controller. Latches rising   |
// |          edges of irq_in, raises n_int_req for unmasked pending      |
// |          sources and answers M1+IORQ with a vector on d_out.         |
// |   clk28     : 28 MHz system clock                                    |
// |   rst_n     : asynchronous active-low reset                          |
// |   bus       : decoded CPU bus (a, d, iorq, rd, wr, m1)               |
// |   clkcpu_ck : one-clk28 pulse per CPU clock rising edge              |
// |   irq_in    : interrupt sources, rising-edge sensitive               |
// |   n_int_req : active-low request toward the INT merge                |
// |   d_out/oe  : read / acknowledge data and its enable                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module irq_vector_responder
  import irq_vector_responder_pkg::*;
#(
  parameter int         NSRC    = 4,
  parameter logic [7:0] PORT_LO = INTCTL_PORT_LO
) (
  input  logic            clk28,
  input  logic            rst_n,
  cpu_bus.slave           bus,
  input  logic            clkcpu_ck,
  input  logic [NSRC-1:0] irq_in,
  output logic            n_int_req,
  output logic [7:0]      d_out,
  output logic            oe
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  irq_ack_state_t  state_q, state_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            in_service_q, in_service_d;
  logic [7:0]      vec_base_q, vec_base_d;
  logic [7:0]      vector_q, vector_d;
  logic            n_int_req_q, n_int_req_d;
  logic            oe_q, oe_d;
  logic [7:0]      d_out_q, d_out_d;
  logic            wr_prev_q;

  logic [NSRC-1:0] irq_rise;
  logic [NSRC-1:0] pend_clr;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            req;
  logic            port_sel;
  logic            wr_stb;
  logic [6:0]      status_pend;
  logic [7:0]      rd_data;

  assign irq_rise = irq_in & ~irq_prev_q;

  irq_prio_enc #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_prio (
    .req_vec (pending_q & mask_q),
    .idx     (win_idx),
    .valid   (win_any)
  );

  // No nesting: an in-service interrupt blocks any new request until EOI.
  assign req = win_any && !in_service_q;

  // m1 gates the decode, so an acknowledge never looks like a port access.
  assign port_sel = bus.iorq && !bus.m1 && (bus.a[7:0] == PORT_LO) &&
                    ((bus.a[15:8] == INTCTL_MASK) ||
                     (bus.a[15:8] == INTCTL_VBASE) ||
                     (bus.a[15:8] == INTCTL_EOI));

  // A long wr strobe spans many clk28 cycles; act only on its first one.
  assign wr_stb = bus.wr && !wr_prev_q;

  always_comb begin
    status_pend = '0;
    for (int i = 0; (i < NSRC) && (i < 7); i++) begin
      status_pend[i] = pending_q[i];
    end
  end

  always_comb begin
    case (bus.a[15:8])
      INTCTL_MASK:  rd_data = {in_service_q, status_pend};
      INTCTL_VBASE: rd_data = vec_base_q;
      default:      rd_data = 8'hFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    mask_d       = mask_q;
    vec_base_d   = vec_base_q;
    pend_clr     = '0;
    oe_d         = 1'b0;
    d_out_d      = 8'hFF;

    case (state_q)
      IDLE: begin
        if (clkcpu_ck && bus.m1 && bus.iorq) begin
          state_d = ACK;
        end else if (port_sel && bus.rd) begin
          oe_d    = 1'b1;
          d_out_d = rd_data;
        end
      end
      ACK: begin
        state_d = DRIVE;
        if (req) begin
          pend_clr[win_idx] = 1'b1;
          in_service_d      = 1'b1;
          vector_d          = {vec_base_q[7:IW+1], win_idx, 1'b0};
        end else begin
          // Spurious acknowledge: hand the CPU a harmless all-ones vector.
          vector_d = 8'hFF;
        end
        oe_d    = 1'b1;
        d_out_d = vector_d;
      end
      DRIVE: begin
        if (!bus.iorq) begin
          state_d = IDLE;
        end else begin
          oe_d    = 1'b1;
          d_out_d = vector_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (port_sel && wr_stb) begin
      case (bus.a[15:8])
        INTCTL_MASK:  mask_d       = bus.d[NSRC-1:0];
        INTCTL_VBASE: vec_base_d   = bus.d;
        INTCTL_EOI:   in_service_d = 1'b0;
        default:      ;
      endcase
    end

    // Set after clear so a new edge survives a same-cycle acknowledge clear.
    pending_d   = (pending_q & ~pend_clr) | irq_rise;
    n_int_req_d = !req;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= 1'b0;
      vec_base_q   <= 8'hFF;
      vector_q     <= 8'hFF;
      n_int_req_q  <= 1'b1;
      oe_q         <= 1'b0;
      d_out_q      <= 8'hFF;
      wr_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      vec_base_q   <= vec_base_d;
      vector_q     <= vector_d;
      n_int_req_q  <= n_int_req_d;
      oe_q         <= oe_d;
      d_out_q      <= d_out_d;
      wr_prev_q    <= bus.wr;
    end
  end

  assign n_int_req = n_int_req_q;
  assign oe        = oe_q;
  assign d_out     = d_out_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_vector_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_irq_vector_responder                                     |
// | Purpose: Scoreboard bench for irq_vector_responder. Expected d_out   |
// |          values are queued by the stimulus; a monitor pops one each  |
// |          time oe rises and compares.                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_irq_vector_responder;

  logic       clk28     = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clkcpu_ck = 1'b0;
  logic [3:0] irq_in    = 4'b0000;
  logic       n_int_req;
  logic [7:0] d_out;
  logic       oe;

  cpu_bus bus_if ();

  irq_vector_responder #(
    .NSRC    (4),
    .PORT_LO (8'h3B)
  ) dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .clkcpu_ck (clkcpu_ck),
    .irq_in    (irq_in),
    .n_int_req (n_int_req),
    .d_out     (d_out),
    .oe        (oe)
  );

  always #5 clk28 = ~clk28;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       oe_seen = 1'b0;
  logic [7:0] exp_val;
  int         ck_cnt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // CPU clock at clk28/4.
  initial begin
    forever begin
      @(posedge clk28);
      #1;
      ck_cnt++;
      clkcpu_ck = ((ck_cnt % 4) == 0);
    end
  end

  // Monitor: one comparison per oe assertion.
  always @(negedge clk28) begin
    if (rst_n && oe && !oe_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_oe: got d_out %h expected no output", d_out);
      end else begin
        exp_val = exp_q.pop_front();
        check("oe_data", d_out, exp_val);
      end
    end
    oe_seen = oe;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk28);
      #1;
    end
  endtask

  task automatic io_read(input logic [15:0] addr, input logic [7:0] want);
    exp_q.push_back(want);
    bus_if.a    = addr;
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b1;
    bus_if.rd   = 1'b1;
    tick(3);
    bus_if.rd   = 1'b0;
    bus_if.iorq = 1'b0;
    tick(2);
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    bus_if.a    = addr;
    bus_if.d    = data;
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b1;
    bus_if.wr   = 1'b1;
    tick(3);
    bus_if.wr   = 1'b0;
    bus_if.iorq = 1'b0;
    tick(1);
  endtask

  task automatic int_ack(input logic [7:0] want);
    exp_q.push_back(want);
    bus_if.a    = 16'h00FF;
    bus_if.m1   = 1'b1;
    bus_if.iorq = 1'b1;
    tick(10);
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b0;
    tick(2);
  endtask

  task automatic pulse(input logic [3:0] bits);
    irq_in = bits;
    tick(1);
    irq_in = 4'b0000;
  endtask

  initial begin
    bus_if.a    = 16'h0000;
    bus_if.d    = 8'h00;
    bus_if.iorq = 1'b0;
    bus_if.rd   = 1'b0;
    bus_if.wr   = 1'b0;
    bus_if.m1   = 1'b0;

    // 1: reset state and register reads
    tick(3);
    check("rst_n_int_req", {7'b0, n_int_req}, 8'h01);
    check("rst_oe", {7'b0, oe}, 8'h00);
    check("rst_d_out", d_out, 8'hFF);
    rst_n = 1'b1;
    tick(2);
    io_read(16'h003B, 8'h00);
    io_read(16'h013B, 8'hFF);
    check("t1_n_int_req", {7'b0, n_int_req}, 8'h01);

    // 2: single source acknowledge
    io_write(16'h003B, 8'h06);
    io_write(16'h013B, 8'h80);
    pulse(4'b0100);
    check("t2_req_not_yet", {7'b0, n_int_req}, 8'h01);
    tick(1);
    check("t2_req_low", {7'b0, n_int_req}, 8'h00);
    int_ack(8'h84);
    check("t2_req_released", {7'b0, n_int_req}, 8'h01);
    io_read(16'h003B, 8'h80);
    io_write(16'h023B, 8'h00);
    check("t2_after_eoi", {7'b0, n_int_req}, 8'h01);

    // 3: two sources, priority and no nesting
    pulse(4'b0110);
    tick(2);
    check("t3_req_low", {7'b0, n_int_req}, 8'h00);
    int_ack(8'h82);
    tick(3);
    check("t3_no_nesting", {7'b0, n_int_req}, 8'h01);
    io_read(16'h003B, 8'h84);
    io_write(16'h023B, 8'h00);
    check("t3_req_after_eoi", {7'b0, n_int_req}, 8'h00);
    int_ack(8'h84);
    io_write(16'h023B, 8'h00);

    // 4: masked source stays pending
    pulse(4'b0001);
    tick(2);
    check("t4_masked_no_req", {7'b0, n_int_req}, 8'h01);
    io_read(16'h003B, 8'h01);
    io_read(16'h023B, 8'hFF);
    io_write(16'h003B, 8'h07);
    check("t4_unmask_req", {7'b0, n_int_req}, 8'h00);
    int_ack(8'h80);
    io_write(16'h023B, 8'h00);
    io_read(16'h003B, 8'h00);

    // 5: spurious acknowledge
    int_ack(8'hFF);
    io_read(16'h003B, 8'h00);
    check("t5_n_int_req", {7'b0, n_int_req}, 8'h01);

    // 6: reset during DRIVE
    pulse(4'b0100);
    tick(1);
    exp_q.push_back(8'h84);
    bus_if.a    = 16'h00FF;
    bus_if.m1   = 1'b1;
    bus_if.iorq = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (oe) break;
      @(negedge clk28);
    end
    check("t6_oe_up", {7'b0, oe}, 8'h01);
    @(negedge clk28);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", {7'b0, oe}, 8'h00);
    check("t6_rst_n_int_req", {7'b0, n_int_req}, 8'h01);
    check("t6_rst_d_out", d_out, 8'hFF);
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    io_read(16'h003B, 8'h00);
    io_read(16'h013B, 8'hFF);
    pulse(4'b0100);
    tick(2);
    check("t6_mask_cleared", {7'b0, n_int_req}, 8'h01);
    io_read(16'h003B, 8'h04);

    tick(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
